// File: rtl/pattern_seq_gen.sv
// Pattern sequencer: streams FIRST / PATS / LAST phases of PHASE_LEN words
// into a FIFO; PATS patterns come from a small table indexed by a step count.
// Ports: clk/rst; start/cont control; mode, num_subc, change_subc, change_no,
// pat_start, pat_stop config; tbl_* table write; fifo_full in; fifo_wr/pat_out
// FIFO write; subc_cnt, busy, frame_done status.
module pattern_seq_gen #(
  parameter int PAT_W     = 10,
  parameter int NUM_ROWS  = 160,
  parameter int ROW_WORDS = 18,
  parameter int TBL_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cont,
  input  logic [1:0]                   mode,
  input  logic [CNT_W-1:0]             num_subc,
  input  logic [CNT_W-1:0]             change_subc,
  input  logic [CNT_W-1:0]             change_no,
  input  logic [PAT_W-1:0]             pat_start,
  input  logic [PAT_W-1:0]             pat_stop,
  input  logic                         tbl_we,
  input  logic [$clog2(TBL_DEPTH)-1:0] tbl_waddr,
  input  logic [PAT_W-1:0]             tbl_wdata,
  input  logic                         fifo_full,
  output logic                         fifo_wr,
  output logic [PAT_W-1:0]             pat_out,
  output logic [CNT_W-1:0]             subc_cnt,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int PHASE_LEN = NUM_ROWS * ROW_WORDS;
  localparam int WC_W      = $clog2(PHASE_LEN + 1);
  localparam int AW        = $clog2(TBL_DEPTH);

  typedef enum logic [1:0] {IDLE, FIRST, PATS, LAST} state_t;

  state_t           state_q;
  logic [WC_W-1:0]  wc_q;
  logic [CNT_W-1:0] step_q, grp_q, subc_q;
  logic [CNT_W-1:0] num_subc_q, change_subc_q, change_no_q;
  logic [1:0]       mode_q;
  logic [PAT_W-1:0] pat_start_q, pat_stop_q, pat_q;
  logic [PAT_W-1:0] tbl_q [TBL_DEPTH];

  logic             phase_end, relatch, grp_wrap, inv;
  logic [CNT_W-1:0] step_d, grp_d, subc_d, use_step;
  logic [AW-1:0]    tidx;
  logic [PAT_W-1:0] pats_pat;

  assign busy       = (state_q != IDLE);
  assign fifo_wr    = busy & ~fifo_full;
  assign phase_end  = fifo_wr && (wc_q == WC_W'(PHASE_LEN - 1));
  assign frame_done = phase_end && (state_q == LAST);
  assign relatch    = ((state_q == IDLE) && start) || (frame_done && cont);
  assign pat_out    = pat_q;
  assign subc_cnt   = subc_q;

  // Step advances once every change_subc completed subframes, saturating.
  always_comb begin
    subc_d   = subc_q + CNT_W'(1);
    grp_wrap = (change_subc_q != '0) && (grp_q + CNT_W'(1) == change_subc_q);
    grp_d    = (grp_wrap || change_subc_q == '0) ? '0 : grp_q + CNT_W'(1);
    step_d   = (grp_wrap && step_q < change_no_q) ? step_q + CNT_W'(1) : step_q;
    // Leaving FIRST, step_q is still 0 for subframe 0.
    use_step = (state_q == PATS) ? step_d : step_q;
    tidx     = '0;
    inv      = 1'b0;
    unique case (mode_q)
      2'b00: ;
      2'b01: inv = use_step[0];
      2'b10: tidx = use_step[AW-1:0];
      2'b11: begin
        tidx = use_step[AW:1];
        inv  = use_step[0];
      end
      default: ;
    endcase
    pats_pat = tbl_q[tidx] ^ {PAT_W{inv}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TBL_DEPTH; i++) tbl_q[i] <= '1;
    end else if (tbl_we) begin
      tbl_q[tbl_waddr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wc_q          <= '0;
      step_q        <= '0;
      grp_q         <= '0;
      subc_q        <= '0;
      pat_q         <= '0;
      mode_q        <= '0;
      num_subc_q    <= '0;
      change_subc_q <= '0;
      change_no_q   <= '0;
      pat_start_q   <= '0;
      pat_stop_q    <= '0;
    end else begin
      if (fifo_wr) wc_q <= phase_end ? '0 : wc_q + WC_W'(1);
      if (relatch) begin
        mode_q        <= mode;
        num_subc_q    <= num_subc;
        change_subc_q <= change_subc;
        change_no_q   <= change_no;
        pat_start_q   <= pat_start;
        pat_stop_q    <= pat_stop;
        pat_q         <= pat_start;
        wc_q          <= '0;
        step_q        <= '0;
        grp_q         <= '0;
        subc_q        <= '0;
        state_q       <= FIRST;
      end else if (phase_end) begin
        unique case (state_q)
          FIRST: begin
            if (num_subc_q == '0) begin
              state_q <= LAST;
              pat_q   <= pat_stop_q;
            end else begin
              state_q <= PATS;
              pat_q   <= pats_pat;
            end
          end
          PATS: begin
            subc_q <= subc_d;
            grp_q  <= grp_d;
            step_q <= step_d;
            if (subc_d == num_subc_q) begin
              state_q <= LAST;
              pat_q   <= pat_stop_q;
            end else begin
              pat_q   <= pats_pat;
            end
          end
          LAST: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Scoreboard bench for pattern_seq_gen with a 6-word phase
// (2 rows x 3 words); directed frames, backpressure, stall and reset.
module tb_pattern_seq_gen;

  logic        clk, rst, start, cont, tbl_we, fifo_full;
  logic [1:0]  mode, tbl_waddr;
  logic [31:0] num_subc, change_subc, change_no, subc_cnt;
  logic [9:0]  pat_start, pat_stop, tbl_wdata, pat_out;
  logic        fifo_wr, busy, frame_done;

  pattern_seq_gen #(
    .PAT_W(10), .NUM_ROWS(2), .ROW_WORDS(3), .TBL_DEPTH(4), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .mode(mode),
    .num_subc(num_subc), .change_subc(change_subc),
    .change_no(change_no), .pat_start(pat_start), .pat_stop(pat_stop),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .pat_out(pat_out),
    .subc_cnt(subc_cnt), .busy(busy), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [9:0] pat;
    logic       done;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   cyc = 0;
  int   first_cyc = -1;
  int   last_cyc = 0;
  bit   bp_en = 0;
  logic hold_full = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Backpressure driver: random when enabled, else the directed level.
  initial begin
    fifo_full = 0;
    forever begin
      @(posedge clk);
      #1;
      fifo_full = bp_en ? 1'($urandom_range(0, 1)) : hold_full;
    end
  end

  // Monitor: pop one expected word per observed write.
  always @(negedge clk) begin
    if (fifo_wr) begin
      checks++;
      if (fifo_full) begin
        errors++;
        $display("FAIL wr_while_full: fifo_wr=1 fifo_full=1");
      end
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL extra_write: pat=%h done=%b, none expected",
                 pat_out, frame_done);
      end else begin
        me = q.pop_front();
        if (pat_out !== me.pat || frame_done !== me.done) begin
          errors++;
          $display("FAIL word%0d: got pat=%h done=%b want pat=%h done=%b",
                   wr_cnt, pat_out, frame_done, me.pat, me.done);
        end
      end
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      wr_cnt++;
    end else if (frame_done) begin
      checks++;
      errors++;
      $display("FAIL done_no_wr: frame_done without write");
    end
  end

  task automatic check(input string n, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ph(input logic [9:0] p, input bit d);
    for (int i = 0; i < 6; i++) q.push_back('{pat: p, done: d && i == 5});
  endtask

  task automatic wr_tbl(input logic [1:0] a, input logic [9:0] d);
    tbl_we = 1; tbl_waddr = a; tbl_wdata = d;
    tick();
    tbl_we = 0;
  endtask

  task automatic go(input logic [1:0] m, input int ns, input int cs,
                    input int cn, input logic [9:0] ps, input logic [9:0] pe);
    mode = m; num_subc = ns; change_subc = cs; change_no = cn;
    pat_start = ps; pat_stop = pe;
    first_cyc = -1;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_wr(input int n);
    for (int i = 0; i < 1000 && wr_cnt < n; i++) @(negedge clk);
    #1;
    check("wait_wr", longint'(wr_cnt >= n), 1);
  endtask

  task automatic wait_frame(input string n, input int span);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (!busy && q.size() == 0) break;
    end
    check({n, "_left"}, q.size(), 0);
    check({n, "_idle"}, busy, 0);
    if (span >= 0) check({n, "_span"}, last_cyc - first_cyc, span);
  endtask

  int w0;
  logic [9:0]  s_pat;
  logic [31:0] s_subc;

  initial begin
    rst = 1; start = 0; cont = 0; tbl_we = 0; tbl_waddr = 0; tbl_wdata = 0;
    mode = 0; num_subc = 0; change_subc = 0; change_no = 0;
    pat_start = 0; pat_stop = 0;
    repeat (3) tick();
    check("rst_pat", pat_out, 0);
    check("rst_subc", subc_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_wr", fifo_wr, 0);
    check("rst_done", frame_done, 0);
    rst = 0;
    tick();

    // Basic frame
    wr_tbl(0, 10'h155);
    ph(10'h3FF, 0); ph(10'h155, 0); ph(10'h155, 0); ph(10'h000, 1);
    go(2'b00, 2, 0, 0, 10'h3FF, 10'h000);
    wait_frame("basic", 23);

    // Inversion with saturation
    ph(10'h3FF, 0);
    ph(10'h155, 0); ph(10'h155, 0);
    ph(10'h2AA, 0); ph(10'h2AA, 0); ph(10'h2AA, 0); ph(10'h2AA, 0);
    ph(10'h000, 1);
    go(2'b01, 6, 2, 1, 10'h3FF, 10'h000);
    wait_frame("inv", 47);

    // Table cycling, modes 10 and 11
    wr_tbl(0, 10'h001); wr_tbl(1, 10'h002);
    wr_tbl(2, 10'h003); wr_tbl(3, 10'h004);
    ph(10'h3FF, 0);
    ph(10'h001, 0); ph(10'h002, 0); ph(10'h003, 0); ph(10'h004, 0);
    ph(10'h000, 1);
    go(2'b10, 4, 1, 10, 10'h3FF, 10'h000);
    wait_frame("tbl10", 35);
    ph(10'h3FF, 0);
    ph(10'h001, 0); ph(10'h3FE, 0); ph(10'h002, 0); ph(10'h3FD, 0);
    ph(10'h000, 1);
    go(2'b11, 4, 1, 10, 10'h3FF, 10'h000);
    wait_frame("tbl11", 35);

    // Random backpressure on the basic frame
    wr_tbl(0, 10'h155);
    w0 = wr_cnt;
    ph(10'h3FF, 0); ph(10'h155, 0); ph(10'h155, 0); ph(10'h000, 1);
    bp_en = 1;
    go(2'b00, 2, 0, 0, 10'h3FF, 10'h000);
    wait_frame("bp", -1);
    bp_en = 0;
    check("bp_count", wr_cnt - w0, 24);
    tick();

    // num_subc = 0
    ph(10'h0F0, 0); ph(10'h00F, 1);
    go(2'b00, 0, 0, 0, 10'h0F0, 10'h00F);
    wait_frame("nsub0", 11);

    // cont: two frames back to back
    w0 = wr_cnt;
    ph(10'h111, 0); ph(10'h222, 1); ph(10'h111, 0); ph(10'h222, 1);
    cont = 1;
    go(2'b00, 0, 0, 0, 10'h111, 10'h222);
    wait_wr(w0 + 14);
    cont = 0;
    wait_frame("cont", 23);

    // start and config changes while busy are ignored
    ph(10'h3FF, 0); ph(10'h155, 0); ph(10'h000, 1);
    go(2'b00, 1, 0, 0, 10'h3FF, 10'h000);
    w0 = wr_cnt - 1;
    wait_wr(w0 + 3);
    mode = 2'b11; num_subc = 5; pat_start = 10'h0AA; pat_stop = 10'h055;
    start = 1;
    tick();
    start = 0;
    wait_frame("busy_start", 17);

    // Stall plus mid-frame table write
    ph(10'h3FF, 0); ph(10'h155, 0); ph(10'h0AA, 0); ph(10'h000, 1);
    w0 = wr_cnt;
    go(2'b00, 2, 0, 0, 10'h3FF, 10'h000);
    wait_wr(w0 + 8);
    wr_tbl(0, 10'h0AA);
    hold_full = 1;
    tick();
    tick();
    s_pat = pat_out; s_subc = subc_cnt; w0 = wr_cnt;
    repeat (20) tick();
    check("stall_pat", pat_out, s_pat);
    check("stall_subc", subc_cnt, s_subc);
    check("stall_wr", wr_cnt, w0);
    check("stall_busy", busy, 1);
    hold_full = 0;
    wait_frame("stall", -1);

    // Asynchronous reset mid-frame
    ph(10'h3FF, 0); ph(10'h0AA, 0); ph(10'h000, 1);
    w0 = wr_cnt;
    go(2'b00, 1, 0, 0, 10'h3FF, 10'h000);
    wait_wr(w0 + 10);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    check("arst_pat", pat_out, 0);
    check("arst_subc", subc_cnt, 0);
    check("arst_busy", busy, 0);
    check("arst_wr", fifo_wr, 0);
    check("arst_done", frame_done, 0);
    q.delete();
    repeat (2) tick();
    rst = 0;
    tick();
    // Table came back all-ones
    ph(10'h001, 0); ph(10'h3FF, 0); ph(10'h002, 1);
    go(2'b00, 1, 0, 0, 10'h001, 10'h002);
    wait_frame("post_rst", 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_seq_gen.md
PATTERN_SEQ_GEN -- requirements
Module: pattern_seq_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PAT_W, 10: pattern word width.
- NUM_ROWS, 160: sensor pixel rows.
- ROW_WORDS, 18: FIFO words per row.
- TBL_DEPTH, 4: pattern table entries, power of 2, at least 2.
- CNT_W, 32: counter and config width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle pulse; begins a frame.
- cont, in, 1: 1 restarts a frame automatically after LAST.
- mode, in, 2: pattern mode (REQ-012).
- num_subc, in, CNT_W: exposed subframes per frame.
- change_subc, in, CNT_W: subframes per pattern step.
- change_no, in, CNT_W: step saturation value.
- pat_start, in, PAT_W: unexposed first-subframe pattern.
- pat_stop, in, PAT_W: unexposed last-subframe pattern.
- tbl_we, in, 1: table write enable.
- tbl_waddr, in, log2(TBL_DEPTH): table write address.
- tbl_wdata, in, PAT_W: table write data.
- fifo_full, in, 1: downstream FIFO full.
- fifo_wr, out, 1: FIFO write strobe.
- pat_out, out, PAT_W: FIFO write data.
- subc_cnt, out, CNT_W: current exposed subframe index.
- busy, out, 1: frame in progress.
- frame_done, out, 1: one-cycle pulse at end of LAST.

Function
REQ-003 The block SHALL implement states IDLE, FIRST, PATS, LAST.
REQ-004 PHASE_LEN SHALL equal NUM_ROWS*ROW_WORDS words; the word counter SHALL be wide enough to hold PHASE_LEN.
REQ-005 fifo_wr SHALL be combinational: (state is FIRST, PATS or LAST) AND NOT fifo_full.
REQ-006 The word counter SHALL increment only on cycles with fifo_wr=1.
REQ-007 pat_out SHALL be registered and held constant for an entire phase.
REQ-008 On the write that completes PHASE_LEN, the next phase's pattern SHALL load on the same edge, so the following cycle writes the new pattern with no idle gap.
REQ-009 IDLE plus start=1 SHALL, on the same edge:
- latch mode, num_subc, change_subc, change_no, pat_start, pat_stop;
- load pat_out=pat_start;
- clear counters;
- enter FIRST.
REQ-010 Transitions:
- FIRST completes to PATS, or to LAST if num_subc==0.
- Each PATS subframe completes and increments subc_cnt; after subframe num_subc-1, go to LAST with pat_out=pat_stop.
- LAST completes with frame_done=1 for that cycle; go to FIRST (re-latching config) if cont=1, else IDLE.
REQ-011 Step index:
- step=0 at subframe 0;
- step increments after every change_subc completed subframes;
- step saturates at change_no;
- change_subc==0 holds step at 0.
- Implement with incremental counters, no dividers.
REQ-012 PATS pattern per mode, where T is the table and inversion is bitwise:
- 00: T[0].
- 01: T[0], inverted when step is odd.
- 10: T[step mod TBL_DEPTH].
- 11: T[(step>>1) mod TBL_DEPTH], inverted when step is odd.
REQ-013 Table writes SHALL be accepted in any state; a mid-frame write SHALL affect pat_out only from the next subframe load.
REQ-014 start SHALL be ignored while busy=1; config input changes mid-frame SHALL have no effect until the next latch.
REQ-015 busy SHALL equal 1 in FIRST, PATS and LAST.
REQ-016 fifo_full held high SHALL stall the block indefinitely with no state, counter or pat_out change.

Reset
REQ-017 While rst=1, regardless of clk, the block SHALL force:
- state=IDLE; pat_out=0; subc_cnt=0; word and step counters=0; frame_done=0; fifo_wr=0.
- Table contents SHALL reset to all-ones.
REQ-018 rst mid-frame SHALL abort the frame; no frame_done SHALL be produced.

Verification
Bench parameters: NUM_ROWS=2, ROW_WORDS=3, so PHASE_LEN=6.
REQ-019 Basic frame:
- Stimulus: mode=00, num_subc=2, fifo_full=0, T[0]=0x155, pat_start=0x3FF, pat_stop=0x000, start.
- Response: exactly 24 contiguous writes: 6x0x3FF, 12x0x155, 6x0x000; frame_done on the 24th; then IDLE.
REQ-020 Inversion with saturation:
- Stimulus: mode=01, num_subc=6, change_subc=2, change_no=1.
- Response: PATS words = T0,T0,~T0,~T0,~T0,~T0 (6 words each).
REQ-021 Table cycling:
- Stimulus: mode=10, num_subc=4, change_subc=1, change_no=10, T={1,2,3,4}.
- Response: subframes 1,2,3,4; mode=11 with the same inputs gives 1,~1,2,~2.
REQ-022 Backpressure:
- Stimulus: toggle fifo_full randomly.
- Response: fifo_wr never high while full; total write count and order identical to REQ-019.
REQ-023 Edge cases:
- num_subc=0 gives 12 writes (start then stop).
- cont=1 repeats frames back to back with no gap.
- start pulsed while busy changes nothing.
REQ-024 Reset:
- Assert rst asynchronously after 10 writes of a frame.
- Response: outputs at reset values immediately; a new start produces a full correct frame.
